multi_debouncer: RTL and testbench
==================================

// Module: multi_debouncer
// PURPOSE
//  Parametrised N-channel debouncer for buttons and switches; successor to the single-channel debouncer.
//  Per channel: 2-flop synchroniser, stability counter, registered clean level, one-cycle rise/fall pulses.
//  Sits between raw board inputs and the control FSMs (VGA menu, mode select).
//  Optional press-and-hold auto-repeat for menu navigation.
// PARAMETERS
//  N_CH          4    number of independent channels (>=1)
//  STABLE_CYCLES 200  consecutive differing sync samples required to accept a new level (>=1)
//  INIT_VAL      '0   N_CH-bit reset level of the synchroniser and clean output, per channel
//  HOLD_CYCLES   1000 cycles at level 1 before the first repeat pulse (auto-repeat only, >=1)
//  RPT_CYCLES    250  cycles between subsequent repeat pulses (auto-repeat only, >=1)
// PORTS
//  clk     in   1     system clock, all logic on rising edge
//  rst_n   in   1     asynchronous active-low reset
//  en      in   1     1 = debounce active; 0 = freeze clean levels
//  boton   in   N_CH  raw asynchronous inputs
//  salida  out  N_CH  debounced level
//  rise    out  N_CH  1-cycle pulse when salida[i] goes 0->1
//  fall    out  N_CH  1-cycle pulse when salida[i] goes 1->0
//  rpt     out  N_CH  1-cycle auto-repeat pulse; tied 0 when feature compiled out
//  any_evt out  1     OR of all rise|fall|rpt bits, same cycle
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    sync stages = INIT_VAL, salida = INIT_VAL, counters = 0, rise/fall/rpt/any_evt = 0.
//  - Synchroniser: s1 <= boton; s2 <= s1. Counters and salida see only s2.
//  - Counter width: $clog2(STABLE_CYCLES+1). Channels are fully independent.
//  - Per channel, each edge with en=1:
//    - s2 == salida: cnt <= 0. Any agreeing sample restarts the count (glitch rejection).
//    - s2 != salida and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
//    - s2 != salida and cnt == STABLE_CYCLES-1: salida <= s2, cnt <= 0.
//      rise or fall is asserted in the cycle salida first shows the new value.
//  - Counter saturates by construction. It never wraps.
//  - Latency: a clean step on boton appears on salida after 2+STABLE_CYCLES rising edges.
//  - en=0: cnt <= 0, salida holds, rise/fall/rpt = 0; the synchroniser keeps running.
//    Raising en restarts qualification from 0.
//  - Pulses are registered outputs, high for exactly 1 cycle. rise and fall are never both 1 on one channel.
//  - Multiple channels may pulse in the same cycle; any_evt is then a single 1.
//  - Reset mid-count aborts qualification with no pulse. A pending level change is lost.
// CONFIGURATION
//  Macro DEBOUNCER_AUTOREPEAT_EN.
//  - Defined: per-channel hold counter, width $clog2(max(HOLD_CYCLES,RPT_CYCLES)+1), runs while salida[i]==1 and en==1.
//    - First rpt[i] pulse fires HOLD_CYCLES cycles after rise[i].
//    - Further rpt[i] pulses fire every RPT_CYCLES cycles.
//    - Counter clears on fall[i], on en=0 and on reset.
//    - rpt is never coincident with rise.
//  - Undefined: no hold counters are synthesised; rpt = '0; any_evt = OR(rise|fall).
// TESTING
//  Bench parameters: N_CH=4, STABLE_CYCLES=8, INIT_VAL=0, HOLD_CYCLES=20, RPT_CYCLES=5.
//  1. Reset: rst_n=0 with boton=4'hF toggling -> all outputs 0 throughout.
//     Release with boton=0 -> no pulses.
//  2. Clean press: boton[0] 0->1 held -> salida[0]=1 and rise[0]=1 exactly 10 edges later for 1 cycle.
//     Release -> fall[0] after 10 edges.
//  3. Bounce: boton[1] toggles every 3 cycles for 40 cycles, then holds 1 -> no pulse during bounce.
//     Single rise[1] 10 edges after the last toggle.
//  4. Simultaneous: boton=4'b1010 at once -> rise[3] and rise[1] in the same cycle, any_evt=1 for 1 cycle.
//  5. en/reset mid-count: drop en at cnt=5 -> salida held, no pulse; restore en -> rise 8 edges later.
//     Repeat with rst_n pulse -> salida=0, no pulse.
//  6. Auto-repeat (macro on): hold boton[2]=1 -> rise at T, rpt at T+20, T+25, T+30.
//     Release -> fall, no further rpt. Macro off -> rpt stays 0.

Source files
------------

// File: rtl/multi_debouncer.sv
// N-channel debouncer: 2-flop synchroniser, stability counter, clean level and rise/fall pulses.
// Optional press-and-hold auto-repeat is built when DEBOUNCER_AUTOREPEAT_EN is defined.
module multi_debouncer #(
    parameter int unsigned      N_CH          = 4,
    parameter int unsigned      STABLE_CYCLES = 200,
    parameter logic [N_CH-1:0]  INIT_VAL      = '0,
    parameter int unsigned      HOLD_CYCLES   = 1000,
    parameter int unsigned      RPT_CYCLES    = 250
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N_CH-1:0] boton,
    output logic [N_CH-1:0] salida,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] rpt,
    output logic            any_evt
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    // Elaboration-time sanity check of the configuration.
    if (N_CH < 1 || STABLE_CYCLES < 1 || HOLD_CYCLES < 1 || RPT_CYCLES < 1) begin : g_bad_param
        $error("multi_debouncer: N_CH, STABLE_CYCLES, HOLD_CYCLES and RPT_CYCLES must all be >= 1");
    end

    logic [N_CH-1:0] s1;
    logic [N_CH-1:0] s2;
    logic [CW-1:0]   cnt_q [N_CH];
    logic [CW-1:0]   cnt_d [N_CH];
    logic [N_CH-1:0] salida_d;
    logic [N_CH-1:0] rise_d;
    logic [N_CH-1:0] fall_d;
    logic [N_CH-1:0] rpt_d;
    logic            any_evt_d;

    // Synchroniser, stability counters, clean level and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= INIT_VAL;
            s2      <= INIT_VAL;
            salida  <= INIT_VAL;
            rise    <= '0;
            fall    <= '0;
            rpt     <= '0;
            any_evt <= 1'b0;
            for (int i = 0; i < int'(N_CH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1      <= boton;
            s2      <= s1;
            salida  <= salida_d;
            rise    <= rise_d;
            fall    <= fall_d;
            rpt     <= rpt_d;
            any_evt <= any_evt_d;
            for (int i = 0; i < int'(N_CH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Any sample agreeing with the clean level restarts qualification.
    always_comb begin
        salida_d = salida;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            cnt_d[i] = '0;
            if (en && (s2[i] != salida[i])) begin
                if (cnt_q[i] == CNT_LAST) begin
                    salida_d[i] = s2[i];
                    rise_d[i]   = s2[i];
                    fall_d[i]   = ~s2[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

`ifdef DEBOUNCER_AUTOREPEAT_EN
    localparam int unsigned HMAX = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
    localparam int unsigned HW   = $clog2(HMAX + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] RPT_LAST  = HW'(RPT_CYCLES - 1);

    logic [HW-1:0]   hcnt_q [N_CH];
    logic [HW-1:0]   hcnt_d [N_CH];
    logic [N_CH-1:0] phase_q;
    logic [N_CH-1:0] phase_d;

    // Hold counters: phase 0 waits for the first repeat, phase 1 paces the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                hcnt_q[i] <= '0;
            end
        end else begin
            phase_q <= phase_d;
            for (int i = 0; i < int'(N_CH); i++) begin
                hcnt_q[i] <= hcnt_d[i];
            end
        end
    end

    // The rise edge sees salida still 0, so a repeat can never coincide with rise.
    always_comb begin
        phase_d = phase_q;
        rpt_d   = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            hcnt_d[i] = hcnt_q[i];
            if (!en || !salida[i] || fall_d[i]) begin
                hcnt_d[i]  = '0;
                phase_d[i] = 1'b0;
            end else if (hcnt_q[i] == (phase_q[i] ? RPT_LAST : HOLD_LAST)) begin
                hcnt_d[i]  = '0;
                phase_d[i] = 1'b1;
                rpt_d[i]   = 1'b1;
            end else begin
                hcnt_d[i] = hcnt_q[i] + HW'(1);
            end
        end
    end
`else
    assign rpt_d = '0;
`endif

    assign any_evt_d = |(rise_d | fall_d | rpt_d);

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer: expected pulses are queued with their due cycle
// when stimulus is driven and compared against rise/fall/rpt/any_evt/salida every cycle.
module tb_multi_debouncer;

    localparam int unsigned NCH  = 4;
    localparam int unsigned ST   = 8;
    localparam int unsigned HOLD = 20;
    localparam int unsigned RPT  = 5;
    localparam int unsigned LAT  = ST + 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [NCH-1:0] boton;
    logic [NCH-1:0] salida;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
    logic [NCH-1:0] rpt;
    logic           any_evt;

    typedef struct {
        int unsigned    when;
        logic [NCH-1:0] r;
        logic [NCH-1:0] f;
        logic [NCH-1:0] p;
    } exp_t;

    exp_t           sbq[$];
    int unsigned    cyc = 0;
    int             checks = 0;
    int             errors = 0;
    logic [NCH-1:0] exp_sal = '0;

    multi_debouncer #(
        .N_CH(NCH), .STABLE_CYCLES(ST), .INIT_VAL(4'b0000),
        .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .boton(boton),
        .salida(salida), .rise(rise), .fall(fall), .rpt(rpt), .any_evt(any_evt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic expect_evt(input int unsigned when, input logic [NCH-1:0] r,
                              input logic [NCH-1:0] f, input logic [NCH-1:0] p);
        exp_t e;
        e.when = when;
        e.r    = r;
        e.f    = f;
        e.p    = p;
        sbq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Pop everything due this cycle, then compare all outputs.
    always @(negedge clk) begin
        logic [NCH-1:0] er;
        logic [NCH-1:0] ef;
        logic [NCH-1:0] ep;
        er = '0;
        ef = '0;
        ep = '0;
        for (int i = int'(sbq.size()) - 1; i >= 0; i--) begin
            if (sbq[i].when <= cyc) begin
                if (sbq[i].when == cyc) begin
                    er |= sbq[i].r;
                    ef |= sbq[i].f;
                    ep |= sbq[i].p;
                end else begin
                    check("sb_stale", sbq[i].when, cyc);
                end
                sbq.delete(i);
            end
        end
        exp_sal = (exp_sal | er) & ~ef;
        check("rise", 32'(rise), 32'(er));
        check("fall", 32'(fall), 32'(ef));
        check("rpt", 32'(rpt), 32'(ep));
        check("any_evt", 32'(any_evt), 32'(|(er | ef | ep)));
        check("salida", 32'(salida), 32'(exp_sal));
    end

    initial begin
        int unsigned t;
        rst_n = 1'b0;
        en    = 1'b1;
        boton = '0;

        // Reset held while inputs toggle, then released with inputs low.
        for (int i = 0; i < 6; i++) begin
            step(1);
            boton = (i % 2 == 0) ? 4'hF : 4'h0;
        end
        step(1);
        boton = '0;
        step(2);
        rst_n = 1'b1;
        step(20);

        // Clean press and release on channel 0.
        boton[0] = 1'b1;
        expect_evt(cyc + LAT, 4'b0001, 4'b0000, 4'b0000);
        step(30);
        boton[0] = 1'b0;
        expect_evt(cyc + LAT, 4'b0000, 4'b0001, 4'b0000);
        step(20);

        // Bounce on channel 1, ending high.
        for (int i = 0; i < 13; i++) begin
            boton[1] = ~boton[1];
            if (i == 12) expect_evt(cyc + LAT, 4'b0010, 4'b0000, 4'b0000);
            step(3);
        end
        step(20);
        boton[1] = 1'b0;
        expect_evt(cyc + LAT, 4'b0000, 4'b0010, 4'b0000);
        step(20);

        // Simultaneous channels.
        boton = 4'b1010;
        expect_evt(cyc + LAT, 4'b1010, 4'b0000, 4'b0000);
        step(20);
        boton = 4'b0000;
        expect_evt(cyc + LAT, 4'b0000, 4'b1010, 4'b0000);
        step(20);

        // en dropped when the count reaches 5, then restored.
        boton[0] = 1'b1;
        step(7);
        en = 1'b0;
        step(12);
        en = 1'b1;
        expect_evt(cyc + ST, 4'b0001, 4'b0000, 4'b0000);
        step(20);
        boton[0] = 1'b0;
        expect_evt(cyc + LAT, 4'b0000, 4'b0001, 4'b0000);
        step(20);

        // Reset pulse mid-count: pending change is lost.
        boton[0] = 1'b1;
        step(5);
        rst_n = 1'b0;
        boton = '0;
        sbq.delete();
        exp_sal = '0;
        step(2);
        rst_n = 1'b1;
        step(20);

        // Press-and-hold on channel 2, released before the fourth repeat.
        boton[2] = 1'b1;
        t = cyc + LAT;
        expect_evt(t, 4'b0100, 4'b0000, 4'b0000);
`ifdef DEBOUNCER_AUTOREPEAT_EN
        expect_evt(t + HOLD, 4'b0000, 4'b0000, 4'b0100);
        expect_evt(t + HOLD + RPT, 4'b0000, 4'b0000, 4'b0100);
        expect_evt(t + HOLD + 2 * RPT, 4'b0000, 4'b0000, 4'b0100);
`endif
        step(34);
        boton[2] = 1'b0;
        expect_evt(cyc + LAT, 4'b0000, 4'b0100, 4'b0000);
        step(30);

        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
